// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage.
//   pc_state_e       : FSM states (SLOT is only reachable when DELAY_SLOT_EN is defined)
//   INSTR_BYTES      : bytes per instruction, sequential PC increment
//   DEFAULT_RESET_PC : default fetch address after reset
package pc_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SLOT = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target selection (purely combinational).
//   i_pc_plus4       : sequential address, base for branch offsets
//   i_branch_taken   : conditional branch resolved taken
//   i_branch_imm     : sign-extended branch offset in words
//   i_jump           : J/JAL, target i_jump_addr
//   i_jump_addr      : pre-formed jump target
//   i_jr             : JR/JALR, target i_jr_addr
//   i_jr_addr        : register-sourced target
//   o_redirect       : some redirect is requested
//   o_target         : selected redirect target (priority jr > jump > branch)
//   o_misaligned     : selected target is not word aligned
module pc_next_sel
  import pc_pkg::*;
(
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_imm,
  input  logic        i_jump,
  input  logic [31:0] i_jump_addr,
  input  logic        i_jr,
  input  logic [31:0] i_jr_addr,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic [31:0] w_branch_target;

  // Word offset scaled to bytes; wraps mod 2^32.
  assign w_branch_target = i_pc_plus4 + (i_branch_imm * INSTR_BYTES);

  always_comb begin
    o_redirect = i_jr | i_jump | i_branch_taken;
    if (i_jr)
      o_target = i_jr_addr;
    else if (i_jump)
      o_target = i_jump_addr;
    else
      o_target = w_branch_target;
  end

  assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds PC, selects next PC, traps misaligned redirects,
// counts retired (non-stalled RUN/SLOT) cycles.
// Optional feature macro: DELAY_SLOT_EN (branch delay slot via SLOT state).
//   clk            : clock, rising edge
//   reset          : synchronous, active-high
//   stall          : hold all state, drop redirects this cycle
//   branch_taken / branch_imm : conditional branch and word offset
//   jump / jump_addr          : J/JAL and its target
//   jr / jr_addr              : JR/JALR and its target
//   pc             : current fetch address
//   pc_plus4       : pc + 4 (combinational, wraps)
//   in_delay_slot  : current instruction is a delay slot (0 without macro)
//   misalign_err   : sticky misaligned-redirect trap
//   retired        : retired-cycle counter
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_imm,
  input  logic             jump,
  input  logic [31:0]      jump_addr,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             in_delay_slot,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired
);

  pc_state_e        r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_misaligned;
  logic [31:0]      w_pc_plus4;
`ifdef DELAY_SLOT_EN
  logic [31:0]      r_pend, w_pend_nxt;
`endif

  assign w_pc_plus4 = r_pc + 32'(INSTR_BYTES);

  pc_next_sel u_next_sel (
    .i_pc_plus4     (w_pc_plus4),
    .i_branch_taken (branch_taken),
    .i_branch_imm   (branch_imm),
    .i_jump         (jump),
    .i_jump_addr    (jump_addr),
    .i_jr           (jr),
    .i_jr_addr      (jr_addr),
    .o_redirect     (w_redirect),
    .o_target       (w_target),
    .o_misaligned   (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= RUN;
      r_pc      <= RESET_PC;
      r_err     <= 1'b0;
      r_retired <= '0;
`ifdef DELAY_SLOT_EN
      r_pend    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_err   <= w_err_nxt;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
`ifdef DELAY_SLOT_EN
      r_pend  <= w_pend_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_err_nxt   = r_err;
    w_retire    = 1'b0;
`ifdef DELAY_SLOT_EN
    w_pend_nxt  = r_pend;
`endif
    if (!stall) begin
      case (r_state)
        RUN: begin
          if (!w_redirect) begin
            w_pc_nxt = w_pc_plus4;
            w_retire = 1'b1;
          end else if (w_misaligned) begin
            // Trap: PC holds and the faulting cycle does not retire.
            w_err_nxt   = 1'b1;
            w_state_nxt = HALT;
          end else begin
`ifdef DELAY_SLOT_EN
            w_pend_nxt  = w_target;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = SLOT;
`else
            w_pc_nxt    = w_target;
`endif
            w_retire    = 1'b1;
          end
        end
`ifdef DELAY_SLOT_EN
        SLOT: begin
          // Redirect inputs are ignored while the slot instruction issues.
          w_pc_nxt    = r_pend;
          w_state_nxt = RUN;
          w_retire    = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_plus4     = w_pc_plus4;
  assign misalign_err = r_err;
  assign retired      = r_retired;
`ifdef DELAY_SLOT_EN
  assign in_delay_slot = (r_state == SLOT);
`else
  assign in_delay_slot = 1'b0;
`endif

endmodule
